uart_tx_sequencer: RTL and testbench
====================================

// Module: uart_tx_sequencer
// PURPOSE
//  Drains 32-bit words from the show-ahead TX FIFO into the byte-wide UART
//  transmitter. Each word is sent as BYTES_PER_WORD bytes. The block owns the
//  tx_ena/tx_busy handshake, the byte index and FIFO pop timing. It sits
//  between the FIFO read port and the uart core's tx_ena/tx_data/tx_busy pins.
// PARAMETERS
//  DATA_WIDTH      32  width of FIFO word; must equal 8*BYTES_PER_WORD max
//  BYTES_PER_WORD  4   bytes sent per word (1..4); unsent upper bytes ignored
//  MSB_FIRST       1   1: byte [31:24] first; 0: byte [7:0] first
//  BUSY_TIMEOUT    15  cycles to wait for tx_busy rise after tx_ena
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous, active-low reset
//  enable       in   1   permit starting new words
//  fifo_empty   in   1   FIFO empty; fifo_data valid when low
//  fifo_data    in   32  head-of-FIFO word (show-ahead)
//  fifo_rd_en   out  1   one-cycle pop strobe
//  tx_busy      in   1   uart transmitter busy
//  tx_ena       out  1   one-cycle byte-start strobe to uart
//  tx_data      out  8   byte to transmit; stable from ISSUE through DRAIN
//  busy         out  1   high whenever state != IDLE
//  words_sent   out  16  count of completed words; wraps 0xFFFF->0
//  err          out  1   sticky: tx_busy never rose within BUSY_TIMEOUT
//  err_clr      in   1   synchronous clear of err (set has priority)
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, word_q=0, idx=0, timer=0.
//  FSM, one transition per clk:
//   IDLE : enable & !fifo_empty & !tx_busy -> LOAD
//   LOAD : word_q<=fifo_data, fifo_rd_en=1, idx<=0 -> ISSUE
//   ISSUE: when !tx_busy: tx_ena=1 (one cycle), timer<=0 -> ACK
//   ACK  : tx_busy=1 -> DRAIN; timer==BUSY_TIMEOUT -> err<=1, -> NEXT;
//          else timer++
//   DRAIN: tx_busy=0 -> NEXT
//   NEXT : idx==BYTES_PER_WORD-1 -> words_sent++, -> IDLE;
//          else idx++ -> ISSUE
//  Byte select: MSB_FIRST=1 byte k = word_q[31-8k -: 8] for k=idx; else
//   word_q[8k +: 8]. With BYTES_PER_WORD<4 only the first N bytes in the
//   chosen order are sent.
//  Latency: enable & word present at cycle 0 -> fifo_rd_en at cycle 1 ->
//   first tx_ena at cycle 2. Minimum one-cycle IDLE gap between words.
//  fifo_rd_en asserts exactly once per word, only in LOAD; never when empty.
//  enable low mid-word: current word completes, then stays IDLE.
//  fifo_empty rising mid-word: no effect (word already held in word_q).
//  Timeout: byte counted as sent; sequencing continues; err stays set.
//  err_clr and timeout in same cycle: err=1.
//  words_sent: 16-bit, modulo wrap, no saturation.
//  reset_n low mid-word: immediate abort, partial word discarded.
// STRUCTURE
//  Shared package uart_pkg: FSM state encoding (IDLE..NEXT, 3 bits),
//   BYTE_W=8, timer width derived from BUSY_TIMEOUT via $clog2.
//  One sub-module: uart_byte_sel (word, idx, MSB_FIRST -> byte),
//   combinational, reusable by the RX side.
// TESTING
//  1 Single word 0xA1B2C3D4, MSB_FIRST=1, uart model busy 10 cyc ->
//    tx_data A1,B2,C3,D4; one fifo_rd_en; words_sent=1.
//  2 MSB_FIRST=0, BYTES_PER_WORD=2, word 0x11223344 -> bytes 44,33 only;
//    no further tx_ena.
//  3 Three words back-to-back with enable held -> 12 tx_ena, 3 pops, no pop
//    while fifo_empty=1, words_sent=3.
//  4 Uart model never raises tx_busy -> err=1 after 16 ACK cycles;
//    remaining 3 bytes still issued; err_clr clears it.
//  5 Drop enable after 2nd byte -> word finishes (4 bytes), next word not
//    popped until enable=1.
//  6 Assert reset_n low during DRAIN -> next cycle all outputs 0, IDLE;
//    preset words_sent=0xFFFF then one word -> wraps to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: the sequencer state encoding,
// the byte width, and the helper that sizes the busy-wait timer.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_ACK   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_NEXT  = 3'd5
  } state_e;

  // Bits needed to count 0..timeout inclusive; never narrower than one bit.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/uart_byte_sel.sv
// Picks byte number idx_i out of a word, counting from the top or bottom end.
// Purely combinational so the RX side can reuse it for reassembly.
module uart_byte_sel
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 2,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [BYTE_W-1:0]     byte_o
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_W;

  // NOTE: the default before the loop keeps this block free of inferred latches.
  always_comb begin
    byte_o = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (idx_i == IDX_W'(k)) begin
        byte_o = MSB_FIRST ? word_i[DATA_WIDTH-1-BYTE_W*k -: BYTE_W]
                           : word_i[BYTE_W*k +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Pops 32-bit words from a show-ahead FIFO and feeds them byte by byte to the
// UART transmitter through the tx_ena/tx_busy handshake.
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTES_PER_WORD = 4,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int BUSY_TIMEOUT   = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  tx_busy,
  output logic                  tx_ena,
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  busy,
  output logic [15:0]           words_sent,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int IDX_W   = 2;
  localparam int TIMER_W = timer_width(BUSY_TIMEOUT);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(BUSY_TIMEOUT);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic [IDX_W-1:0]        idx_q;
  logic [TIMER_W-1:0]      timer_q;
  logic [15:0]             words_sent_q;
  logic                    err_q;
  logic                    fifo_rd_en_q;
  logic                    busy_q;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; word_q is a single register, so it is reset too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      words_sent_q <= '0;
      err_q        <= 1'b0;
      fifo_rd_en_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // A timeout later in this block overrides the clear.
      if (err_clr) err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (enable && !fifo_empty && !tx_busy) begin
            state_q      <= ST_LOAD;
            fifo_rd_en_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_LOAD: begin
          word_q       <= fifo_data;
          idx_q        <= '0;
          fifo_rd_en_q <= 1'b0;
          state_q      <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!tx_busy) begin
            timer_q <= '0;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (tx_busy) begin
            state_q <= ST_DRAIN;
          end else if (timer_q == TIMER_MAX) begin
            err_q   <= 1'b1;
            state_q <= ST_NEXT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!tx_busy) state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
            words_sent_q <= words_sent_q + 16'd1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          fifo_rd_en_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  uart_byte_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W),
    .MSB_FIRST  (MSB_FIRST)
  ) u_byte_sel (
    .word_i (word_q),
    .idx_i  (idx_q),
    .byte_o (tx_data)
  );

  // The strobe is decoded from the ISSUE state so the first byte starts two
  // cycles after the word is seen, without waiting an extra cycle.
  assign tx_ena     = (state_q == ST_ISSUE) && !tx_busy;
  assign fifo_rd_en = fifo_rd_en_q;
  assign busy       = busy_q;
  assign words_sent = words_sent_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench: two sequencer instances (MSB-first 4-byte, LSB-first 2-byte)
// with FIFO and UART models, one task per scenario.
module tb_uart_tx_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  int vectors    = 0;
  int miscompares = 0;

  // ---------------- instance 1: defaults ----------------
  logic        enable1, err_clr1, tx_busy1, fifo_rd_en1, tx_ena1, busy1, err1;
  logic        fifo_empty1;
  logic [31:0] fifo_data1;
  logic [7:0]  tx_data1;
  logic [15:0] words_sent1;
  logic [31:0] mem1 [16];
  logic [3:0]  wr1 = '0;
  logic [3:0]  rd1 = '0;
  logic        mute1;
  int          cnt1;
  logic [7:0]  bytes1 [$];
  int          pops1 = 0;
  int          pop_empty1 = 0;

  assign fifo_empty1 = (wr1 == rd1);
  assign fifo_data1  = mem1[rd1];

  uart_tx_sequencer dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable1), .fifo_empty(fifo_empty1),
    .fifo_data(fifo_data1), .fifo_rd_en(fifo_rd_en1), .tx_busy(tx_busy1),
    .tx_ena(tx_ena1), .tx_data(tx_data1), .busy(busy1),
    .words_sent(words_sent1), .err(err1), .err_clr(err_clr1)
  );

  always @(posedge clk) if (fifo_rd_en1 && !fifo_empty1) rd1 <= rd1 + 4'd1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy1 <= 1'b0; cnt1 <= 0;
    end else if (tx_ena1 && !mute1) begin
      tx_busy1 <= 1'b1; cnt1 <= 9;
    end else if (cnt1 > 0) begin
      cnt1 <= cnt1 - 1;
    end else begin
      tx_busy1 <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tx_ena1) bytes1.push_back(tx_data1);
    if (fifo_rd_en1) begin
      pops1++;
      if (fifo_empty1) pop_empty1++;
    end
  end

  // ---------------- instance 2: LSB first, 2 bytes ----------------
  logic        enable2, err_clr2, tx_busy2, fifo_rd_en2, tx_ena2, busy2, err2;
  logic        fifo_empty2;
  logic [31:0] fifo_data2;
  logic [7:0]  tx_data2;
  logic [15:0] words_sent2;
  logic [31:0] mem2 [16];
  logic [3:0]  wr2 = '0;
  logic [3:0]  rd2 = '0;
  int          cnt2;
  logic [7:0]  bytes2 [$];
  int          pops2 = 0;

  assign fifo_empty2 = (wr2 == rd2);
  assign fifo_data2  = mem2[rd2];

  uart_tx_sequencer #(.MSB_FIRST(1'b0), .BYTES_PER_WORD(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable2), .fifo_empty(fifo_empty2),
    .fifo_data(fifo_data2), .fifo_rd_en(fifo_rd_en2), .tx_busy(tx_busy2),
    .tx_ena(tx_ena2), .tx_data(tx_data2), .busy(busy2),
    .words_sent(words_sent2), .err(err2), .err_clr(err_clr2)
  );

  always @(posedge clk) if (fifo_rd_en2 && !fifo_empty2) rd2 <= rd2 + 4'd1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy2 <= 1'b0; cnt2 <= 0;
    end else if (tx_ena2) begin
      tx_busy2 <= 1'b1; cnt2 <= 9;
    end else if (cnt2 > 0) begin
      cnt2 <= cnt2 - 1;
    end else begin
      tx_busy2 <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tx_ena2) bytes2.push_back(tx_data2);
    if (fifo_rd_en2) pops2++;
  end

  // ---------------- helpers (stimulus / bounded waits only) ----------------
  task automatic push1(input logic [31:0] w);
    mem1[wr1] = w;
    wr1 = wr1 + 4'd1;
  endtask

  task automatic wait_words1(input logic [15:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (words_sent1 === target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ena1(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_ena1 === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    vectors++;
    if ({busy1, tx_ena1, fifo_rd_en1, err1} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ctl got=%b want=0000", {busy1, tx_ena1, fifo_rd_en1, err1});
    end
    vectors++;
    if (tx_data1 !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got=%h want=00", tx_data1); end
    vectors++;
    if (words_sent1 !== 16'h0) begin miscompares++; $display("FAIL reset_words got=%h want=0000", words_sent1); end
  endtask

  task automatic test_single_word;
    logic [7:0] exp [4];
    bit ok;
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    bytes1.delete(); pops1 = 0;
    push1(32'hA1B2C3D4);
    enable1 = 1'b1;
    @(negedge clk);
    vectors++;
    if ({fifo_rd_en1, tx_ena1} !== 2'b10) begin
      miscompares++; $display("FAIL lat_pop got rd_en,ena=%b want=10", {fifo_rd_en1, tx_ena1});
    end
    @(negedge clk);
    vectors++;
    if ({fifo_rd_en1, tx_ena1, tx_data1} !== {2'b01, 8'hA1}) begin
      miscompares++; $display("FAIL lat_ena got rd_en,ena=%b data=%h want=01 A1", {fifo_rd_en1, tx_ena1}, tx_data1);
    end
    wait_words1(16'd1, 300, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL single_done got words=%h want=0001", words_sent1); end
    vectors++;
    if (bytes1.size() != 4) begin
      miscompares++; $display("FAIL single_nbytes got=%0d want=4", bytes1.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (bytes1[i] !== exp[i]) begin
          miscompares++; $display("FAIL single_byte%0d got=%h want=%h", i, bytes1[i], exp[i]);
        end
    end
    vectors++;
    if (pops1 != 1) begin miscompares++; $display("FAIL single_pops got=%0d want=1", pops1); end
    vectors++;
    if (busy1 !== 1'b0) begin miscompares++; $display("FAIL single_idle got busy=%b want=0", busy1); end
  endtask

  task automatic test_lsb_two_bytes;
    bit ok;
    mem2[wr2] = 32'h11223344; wr2 = wr2 + 4'd1;
    enable2 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (words_sent2 === 16'd1) begin ok = 1'b1; break; end
    end
    repeat (30) @(negedge clk);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL lsb_done got words=%h want=0001", words_sent2); end
    vectors++;
    if (bytes2.size() != 2) begin
      miscompares++; $display("FAIL lsb_nbytes got=%0d want=2", bytes2.size());
    end else if (bytes2[0] !== 8'h44 || bytes2[1] !== 8'h33) begin
      miscompares++; $display("FAIL lsb_bytes got=%h,%h want=44,33", bytes2[0], bytes2[1]);
    end
    vectors++;
    if (pops2 != 1) begin miscompares++; $display("FAIL lsb_pops got=%0d want=1", pops2); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [12];
    bit ok;
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0A, 8'h0B, 8'h0C};
    bytes1.delete(); pops1 = 0; pop_empty1 = 0;
    push1(32'h01020304); push1(32'h05060708); push1(32'h090A0B0C);
    wait_words1(16'd4, 1000, ok);
    repeat (20) @(negedge clk);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_done got words=%h want=0004", words_sent1); end
    vectors++;
    if (bytes1.size() != 12) begin
      miscompares++; $display("FAIL b2b_nbytes got=%0d want=12", bytes1.size());
    end else begin
      for (int i = 0; i < 12; i++)
        if (bytes1[i] !== exp[i]) begin
          miscompares++; $display("FAIL b2b_byte%0d got=%h want=%h", i, bytes1[i], exp[i]);
        end
    end
    vectors++;
    if (pops1 != 3 || pop_empty1 != 0) begin
      miscompares++; $display("FAIL b2b_pops got=%0d empty_pops=%0d want=3,0", pops1, pop_empty1);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    bytes1.delete();
    mute1 = 1'b1;
    push1(32'hDEADBEEF);
    wait_ena1(20, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL to_first_ena got=none want=tx_ena"); end
    repeat (16) @(negedge clk);
    vectors++;
    if (err1 !== 1'b0) begin miscompares++; $display("FAIL to_early got err=%b want=0", err1); end
    @(negedge clk);
    vectors++;
    if (err1 !== 1'b1) begin miscompares++; $display("FAIL to_set got err=%b want=1", err1); end
    @(negedge clk);
    vectors++;
    if ({tx_ena1, tx_data1} !== {1'b1, 8'hAD}) begin
      miscompares++; $display("FAIL to_next_byte got ena=%b data=%h want=1 AD", tx_ena1, tx_data1);
    end
    wait_words1(16'd5, 300, ok);
    vectors++;
    if (!ok || bytes1.size() != 4) begin
      miscompares++; $display("FAIL to_bytes got n=%0d words=%h want=4 0005", bytes1.size(), words_sent1);
    end else if ({bytes1[0], bytes1[1], bytes1[2], bytes1[3]} !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL to_bytes got=%h%h%h%h want=DEADBEEF", bytes1[0], bytes1[1], bytes1[2], bytes1[3]);
    end
    vectors++;
    if (err1 !== 1'b1) begin miscompares++; $display("FAIL to_sticky got err=%b want=1", err1); end
    err_clr1 = 1'b1;
    @(negedge clk);
    err_clr1 = 1'b0;
    vectors++;
    if (err1 !== 1'b0) begin miscompares++; $display("FAIL to_clr got err=%b want=0", err1); end

    // Clear held high while the timeout fires: the set wins that cycle.
    err_clr1 = 1'b1;
    push1(32'hCAFEF00D);
    wait_ena1(20, ok);
    repeat (17) @(negedge clk);
    vectors++;
    if (err1 !== 1'b1) begin miscompares++; $display("FAIL to_set_prio got err=%b want=1", err1); end
    @(negedge clk);
    vectors++;
    if (err1 !== 1'b0) begin miscompares++; $display("FAIL to_clr_after got err=%b want=0", err1); end
    err_clr1 = 1'b0;
    wait_words1(16'd6, 300, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL to_word2 got words=%h want=0006", words_sent1); end
    mute1 = 1'b0;
    err_clr1 = 1'b1;
    @(negedge clk);
    err_clr1 = 1'b0;
  endtask

  task automatic test_enable_drop;
    bit ok;
    int n;
    bytes1.delete(); pops1 = 0;
    push1(32'h10203040); push1(32'h50607080);
    n = 0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      @(negedge clk);
      if (tx_ena1 === 1'b1) n++;
    end
    enable1 = 1'b0;
    wait_words1(16'd7, 300, ok);
    repeat (40) @(negedge clk);
    vectors++;
    if (!ok || busy1 !== 1'b0) begin
      miscompares++; $display("FAIL en_finish got words=%h busy=%b want=0007 0", words_sent1, busy1);
    end
    vectors++;
    if (pops1 != 1 || bytes1.size() != 4) begin
      miscompares++; $display("FAIL en_hold got pops=%0d bytes=%0d want=1,4", pops1, bytes1.size());
    end else if ({bytes1[0], bytes1[1], bytes1[2], bytes1[3]} !== 32'h10203040) begin
      miscompares++; $display("FAIL en_bytes got=%h%h%h%h want=10203040", bytes1[0], bytes1[1], bytes1[2], bytes1[3]);
    end
    enable1 = 1'b1;
    wait_words1(16'd8, 300, ok);
    vectors++;
    if (!ok || pops1 != 2 || bytes1.size() != 8) begin
      miscompares++; $display("FAIL en_resume got words=%h pops=%0d bytes=%0d want=0008,2,8", words_sent1, pops1, bytes1.size());
    end else if ({bytes1[4], bytes1[5], bytes1[6], bytes1[7]} !== 32'h50607080) begin
      miscompares++; $display("FAIL en_bytes2 got=%h%h%h%h want=50607080", bytes1[4], bytes1[5], bytes1[6], bytes1[7]);
    end
  endtask

  task automatic test_reset_abort;
    bit ok;
    bytes1.delete(); pops1 = 0;
    push1(32'h13579BDF);
    wait_ena1(20, ok);
    repeat (4) @(negedge clk);
    vectors++;
    if (busy1 !== 1'b1) begin miscompares++; $display("FAIL abort_midword got busy=%b want=1", busy1); end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy1, tx_ena1, fifo_rd_en1, err1, tx_data1, words_sent1} !== 28'h0) begin
      miscompares++;
      $display("FAIL abort_outputs got busy=%b ena=%b rd=%b err=%b data=%h words=%h want all 0",
               busy1, tx_ena1, fifo_rd_en1, err1, tx_data1, words_sent1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    vectors++;
    if (busy1 !== 1'b0 || bytes1.size() != 1 || words_sent1 !== 16'h0) begin
      miscompares++; $display("FAIL abort_discard got busy=%b bytes=%0d words=%h want=0,1,0000", busy1, bytes1.size(), words_sent1);
    end

    @(negedge clk);
    force dut1.words_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut1.words_sent_q;
    @(negedge clk);
    vectors++;
    if (words_sent1 !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preset got=%h want=FFFF", words_sent1); end
    push1(32'h2468ACE0);
    wait_words1(16'h0000, 300, ok);
    vectors++;
    if (!ok || busy1 !== 1'b0) begin
      miscompares++; $display("FAIL wrap got words=%h busy=%b want=0000 0", words_sent1, busy1);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem1[i] = '0; mem2[i] = '0; end
    reset_n = 1'b0;
    enable1 = 1'b0; err_clr1 = 1'b0; mute1 = 1'b0;
    enable2 = 1'b0; err_clr2 = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_lsb_two_bytes();
    test_back_to_back();
    test_timeout();
    test_enable_drop();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
